// File: rtl/score_display_bcd.sv
// score_display_bcd: per-player BCD score counter with a 7-segment on-screen renderer.
// Latency: score updates 1 cycle after a score_pulse rising edge; r/g/b lag hcount/vcount by 1 cycle.
// No backpressure: every rising edge of score_pulse is taken unless game_over holds the score.
// Optional: define SCORE_BLINK_EN to blink the digits (32-frame period) while game_over is set.
module score_display_bcd #(
  parameter int NUM_DIGITS = 2,
  parameter int WIN_SCORE  = 11,
  parameter int SEG_LENGTH = 30,
  parameter int SEG_WIDTH  = 10,
  parameter int SEG_X      = 200,
  parameter int SEG_Y      = 20,
  parameter int DIGIT_GAP  = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              hcount,
  input  logic [9:0]              vcount,
  input  logic                    score_pulse,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] score,
  output logic                    game_over,
  output logic                    r,
  output logic                    g,
  output logic                    b
);

  localparam int L  = SEG_LENGTH;
  localparam int W  = SEG_WIDTH;
  localparam int SW = 4 * NUM_DIGITS;

  // Convert the decimal winning score into the packed BCD layout of the score register.
  function automatic logic [SW-1:0] to_bcd(input int v);
    int            t;
    logic [SW-1:0] res;
    t   = v;
    res = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      res[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return res;
  endfunction

  localparam logic [SW-1:0] WIN_BCD = to_bcd(WIN_SCORE);

  // Segment pattern, bit order g..a; anything above 9 is blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0111111;
      4'd1:    seg_decode = 7'b0000110;
      4'd2:    seg_decode = 7'b1011011;
      4'd3:    seg_decode = 7'b1001111;
      4'd4:    seg_decode = 7'b1100110;
      4'd5:    seg_decode = 7'b1101101;
      4'd6:    seg_decode = 7'b1111101;
      4'd7:    seg_decode = 7'b0000111;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1101111;
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

  logic            pulse_prev;
  logic            point;
  logic [SW-1:0]   score_inc;
  logic [SW-1:0]   score_next;
  logic            carry;
  logic [NUM_DIGITS-1:0] digit_on;
  logic            pix_on;
  logic            pix_gated;
  int              hx;
  int              vy;

  assign point = score_pulse & ~pulse_prev;
  assign hx    = {22'd0, hcount};
  assign vy    = {22'd0, vcount};

  // BCD ripple increment; a carry out of the top digit means all nines, so hold the value.
  always_comb begin
    score_inc = score;
    carry     = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (carry) begin
        if (score_inc[4*k +: 4] == 4'd9) begin
          score_inc[4*k +: 4] = 4'd0;
        end else begin
          score_inc[4*k +: 4] = score_inc[4*k +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    score_next = carry ? score : score_inc;
  end

  // Score, win flag and edge detector. During reset/clear the edge register tracks the
  // input so a pulse held across the release is not mistaken for a new point.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      score      <= '0;
      game_over  <= 1'b0;
      pulse_prev <= score_pulse;
    end else begin
      pulse_prev <= score_pulse;
      if (point && !game_over) begin
        score <= score_next;
        if (score_next == WIN_BCD) game_over <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam int X0 = SEG_X + (NUM_DIGITS - 1 - i) * (SEG_LENGTH + DIGIT_GAP);
    localparam int Y0 = SEG_Y;
    logic [6:0] hit;
    logic [6:0] mask;
    logic       blank;

    assign hit[0] = (hx > X0)         && (hx < X0 + L) && (vy > Y0)             && (vy < Y0 + W);
    assign hit[1] = (hx > X0 + L - W) && (hx < X0 + L) && (vy > Y0)             && (vy < Y0 + L);
    assign hit[2] = (hx > X0 + L - W) && (hx < X0 + L) && (vy > Y0 + L - W)     && (vy < Y0 + 2*L - W);
    assign hit[3] = (hx > X0)         && (hx < X0 + L) && (vy > Y0 + 2*L - 2*W) && (vy < Y0 + 2*L - W);
    assign hit[4] = (hx > X0)         && (hx < X0 + W) && (vy > Y0 + L - W)     && (vy < Y0 + 2*L - W);
    assign hit[5] = (hx > X0)         && (hx < X0 + W) && (vy > Y0)             && (vy < Y0 + L);
    assign hit[6] = (hx > X0)         && (hx < X0 + L) && (vy > Y0 + L - W)     && (vy < Y0 + L);

    assign mask = seg_decode(score[4*i +: 4]);

    // Leading-zero blanking: a higher digit disappears while it and everything above it is 0.
    if (i == 0) begin : g_lsd
      assign blank = 1'b0;
    end else begin : g_msd
      assign blank = (score[SW-1:4*i] == '0);
    end

    assign digit_on[i] = ~blank & (|(hit & mask));
  end

  assign pix_on = |digit_on;

`ifdef SCORE_BLINK_EN
  logic [4:0] frame_cnt;

  // Frame counter advances once per frame at the top-left pixel.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      frame_cnt <= 5'd0;
    end else if (hcount == 10'd0 && vcount == 10'd0) begin
      frame_cnt <= frame_cnt + 5'd1;
    end
  end

  assign pix_gated = pix_on & ~(game_over & frame_cnt[4]);
`else
  assign pix_gated = pix_on;
`endif

  // Registered pixel output; all three colour channels carry the same bit.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r <= 1'b0;
      g <= 1'b0;
      b <= 1'b0;
    end else begin
      r <= pix_gated;
      g <= pix_gated;
      b <= pix_gated;
    end
  end

endmodule
